// File: rtl/alu_pkg.sv
// ALU function codes, arbitration modes and the operation bundle shared by the
// ALU arbiter and its response slots.
package alu_pkg;

    localparam logic [5:0] ALU_ADD   = 6'b000000;
    localparam logic [5:0] ALU_SUB   = 6'b000001;
    localparam logic [5:0] ALU_AND   = 6'b011000;
    localparam logic [5:0] ALU_OR    = 6'b011110;
    localparam logic [5:0] ALU_XOR   = 6'b010110;
    localparam logic [5:0] ALU_NOR   = 6'b010001;
    localparam logic [5:0] ALU_PASSA = 6'b011010;
    localparam logic [5:0] ALU_SLL   = 6'b100000;
    localparam logic [5:0] ALU_SRL   = 6'b100001;
    localparam logic [5:0] ALU_SRA   = 6'b100011;
    localparam logic [5:0] ALU_EQ    = 6'b110011;
    localparam logic [5:0] ALU_NEQ   = 6'b110001;
    localparam logic [5:0] ALU_LT    = 6'b110101;
    localparam logic [5:0] ALU_LEZ   = 6'b111101;
    localparam logic [5:0] ALU_LTZ   = 6'b111011;
    localparam logic [5:0] ALU_GTZ   = 6'b111111;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  fun;
        logic        sign;
    } alu_op_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester's view of the arbiter: request valid/ready with payload, and the
// returned result with its tag.
interface alu_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [5:0]       req_fun;
    logic             req_sign;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_s;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_a, req_b, req_fun, req_sign, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_s, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_fun, req_sign, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_s, rsp_tag
    );
endinterface

// File: rtl/alu_rsp_slot.sv
// One-entry result holding register with valid/ready output; a push and a pop
// in the same cycle replace the entry and keep it valid.
module alu_rsp_slot #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [31:0]      push_s_i,
    input  logic [TAG_W-1:0] push_tag_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic             pop_o,
    output logic [31:0]      s_o,
    output logic [TAG_W-1:0] tag_o
);
    logic             valid_q, valid_d;
    logic [31:0]      s_q, s_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    assign pop_o   = valid_q && ready_i;
    assign valid_o = valid_q;
    assign s_o     = s_q;
    assign tag_o   = tag_q;

    // NOTE: every _d gets its hold value first, so no branch can leave one unassigned and infer a latch.
    always_comb begin
        valid_d = valid_q;
        s_d     = s_q;
        tag_d   = tag_q;
        if (pop_o) begin
            valid_d = 1'b0;
        end
        if (push_i) begin
            valid_d = 1'b1;
            s_d     = push_s_i;
            tag_d   = push_tag_i;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            s_q     <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            s_q     <= s_d;
            tag_q   <= tag_d;
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters: arbitrates,
// registers the winner into an issue stage and captures results per port.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int ARB_MODE     = ARB_RR,
    parameter int STARVE_LIMIT = 4,
    parameter int TAG_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    alu_arbiter_if.slave port0,
    alu_arbiter_if.slave port1,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_fun,
    output logic        alu_sign,
    input  logic [31:0] alu_s,
    output logic        busy
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    logic             req_valid [2];
    logic             req_ready [2];
    alu_op_t          req_op    [2];
    logic [TAG_W-1:0] req_tag   [2];

    logic             slot_push  [2];
    logic             slot_valid [2];
    logic             slot_pop   [2];
    logic [31:0]      slot_s     [2];
    logic [TAG_W-1:0] slot_tag   [2];

    logic             iss_valid_q, iss_valid_d;
    logic             iss_owner_q, iss_owner_d;
    alu_op_t          iss_op_q, iss_op_d;
    logic [TAG_W-1:0] iss_tag_q, iss_tag_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       starve_cnt_q, starve_cnt_d;

    logic advance;
    logic grant_v;
    logic grant_p;

    assign req_valid[0] = port0.req_valid;
    assign req_valid[1] = port1.req_valid;
    assign req_op[0]    = '{a: port0.req_a, b: port0.req_b, fun: port0.req_fun, sign: port0.req_sign};
    assign req_op[1]    = '{a: port1.req_a, b: port1.req_b, fun: port1.req_fun, sign: port1.req_sign};
    assign req_tag[0]   = port0.req_tag;
    assign req_tag[1]   = port1.req_tag;

    // The issue stage may move only if its owner's slot can take the result this edge.
    assign advance = !iss_valid_q || !slot_valid[iss_owner_q] || slot_pop[iss_owner_q];

    always_comb begin
        grant_v = 1'b0;
        grant_p = 1'b0;
        if (advance && !reset) begin
            if (req_valid[0] && req_valid[1]) begin
                grant_v = 1'b1;
                if (ARB_MODE == ARB_FIXED) begin
                    grant_p = (starve_cnt_q == STARVE_LIM);
                end else begin
                    grant_p = !last_grant_q;
                end
            end else if (req_valid[0] || req_valid[1]) begin
                grant_v = 1'b1;
                grant_p = req_valid[1];
            end
        end
    end

    assign req_ready[0]    = grant_v && !grant_p;
    assign req_ready[1]    = grant_v && grant_p;
    assign port0.req_ready = req_ready[0];
    assign port1.req_ready = req_ready[1];

    always_comb begin
        iss_valid_d  = iss_valid_q;
        iss_owner_d  = iss_owner_q;
        iss_op_d     = iss_op_q;
        iss_tag_d    = iss_tag_q;
        last_grant_d = last_grant_q;
        starve_cnt_d = '0;
        if (advance) begin
            iss_valid_d = grant_v;
            if (grant_v) begin
                iss_owner_d = grant_p;
                iss_op_d    = req_op[grant_p];
                iss_tag_d   = req_tag[grant_p];
            end
        end
        if (grant_v) begin
            last_grant_d = grant_p;
        end
        if (ARB_MODE == ARB_FIXED && req_valid[1] && !req_ready[1]) begin
            starve_cnt_d = sat_inc4(starve_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_valid_q  <= 1'b0;
            iss_owner_q  <= 1'b0;
            iss_op_q     <= '0;
            iss_tag_q    <= '0;
            last_grant_q <= 1'b1;
            starve_cnt_q <= '0;
        end else begin
            iss_valid_q  <= iss_valid_d;
            iss_owner_q  <= iss_owner_d;
            iss_op_q     <= iss_op_d;
            iss_tag_q    <= iss_tag_d;
            last_grant_q <= last_grant_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign alu_a    = iss_valid_q ? iss_op_q.a    : '0;
    assign alu_b    = iss_valid_q ? iss_op_q.b    : '0;
    assign alu_fun  = iss_valid_q ? iss_op_q.fun  : '0;
    assign alu_sign = iss_valid_q ? iss_op_q.sign : 1'b0;

    assign slot_push[0] = iss_valid_q && advance && !iss_owner_q;
    assign slot_push[1] = iss_valid_q && advance && iss_owner_q;

    for (genvar p = 0; p < 2; p++) begin : g_slot
        alu_rsp_slot #(.TAG_W(TAG_W)) u_slot (
            .clk        (clk),
            .reset      (reset),
            .push_i     (slot_push[p]),
            .push_s_i   (alu_s),
            .push_tag_i (iss_tag_q),
            .ready_i    ((p == 0) ? port0.rsp_ready : port1.rsp_ready),
            .valid_o    (slot_valid[p]),
            .pop_o      (slot_pop[p]),
            .s_o        (slot_s[p]),
            .tag_o      (slot_tag[p])
        );
    end

    assign port0.rsp_valid = slot_valid[0];
    assign port0.rsp_s     = slot_s[0];
    assign port0.rsp_tag   = slot_tag[0];
    assign port1.rsp_valid = slot_valid[1];
    assign port1.rsp_s     = slot_s[1];
    assign port1.rsp_tag   = slot_tag[1];

    assign busy = iss_valid_q || slot_valid[0] || slot_valid[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance, each
// checked every cycle against a transaction-level model, plus directed literals.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int TW    = 4;
    localparam int LIMIT = 4;

    typedef struct {
        logic [31:0]   a;
        logic [31:0]   b;
        logic [5:0]    fun;
        logic          sign;
        logic [TW-1:0] tag;
        logic [31:0]   s;
    } op_t;

    typedef struct {
        logic [31:0]   s;
        logic [TW-1:0] tag;
        int            cyc;
    } rsp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Stimulus, indexed [instance][port]; instance 0 is round-robin, 1 is fixed priority.
    logic          r_valid [2][2];
    logic [31:0]   r_a     [2][2];
    logic [31:0]   r_b     [2][2];
    logic [5:0]    r_fun   [2][2];
    logic          r_sign  [2][2];
    logic [TW-1:0] r_tag   [2][2];
    logic          r_ready [2][2];

    logic          o_req_ready [2][2];
    logic          o_rsp_valid [2][2];
    logic [31:0]   o_rsp_s     [2][2];
    logic [TW-1:0] o_rsp_tag   [2][2];
    logic [31:0]   o_alu_a  [2];
    logic [31:0]   o_alu_b  [2];
    logic [5:0]    o_alu_fun [2];
    logic          o_alu_sign [2];
    logic [31:0]   o_alu_s  [2];
    logic          o_busy   [2];

    // Model state
    logic m_iss_v [2];
    int   m_owner [2];
    op_t  m_iss   [2];
    logic m_slot_v [2][2];
    op_t  m_slot   [2][2];
    int   m_last   [2];
    int   m_starve [2];

    // Observed grants and delivered responses
    int   grant_log [2][32];
    int   grant_n   [2];
    rsp_t rsp_log   [2][2][16];
    int   rsp_n     [2][2];

    int exp_rr [4]  = '{0, 1, 0, 1};
    int exp_fx [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] fun, input logic sign);
        logic lt;
        lt = sign ? ($signed(a) < $signed(b)) : (a < b);
        case (fun)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_XOR:   return a ^ b;
            ALU_NOR:   return ~(a | b);
            ALU_PASSA: return a;
            ALU_SLL:   return b << a[4:0];
            ALU_SRL:   return b >> a[4:0];
            ALU_SRA:   return $unsigned($signed(b) >>> a[4:0]);
            ALU_EQ:    return {31'd0, a == b};
            ALU_NEQ:   return {31'd0, a != b};
            ALU_LT:    return {31'd0, lt};
            ALU_LEZ:   return {31'd0, a[31] || (a == 32'd0)};
            ALU_LTZ:   return {31'd0, a[31]};
            ALU_GTZ:   return {31'd0, !a[31] && (a != 32'd0)};
            default:   return 32'd0;
        endcase
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        alu_arbiter_if #(.TAG_W(TW)) p0 ();
        alu_arbiter_if #(.TAG_W(TW)) p1 ();

        alu_arbiter #(.ARB_MODE(k), .STARVE_LIMIT(LIMIT), .TAG_W(TW)) dut (
            .clk      (clk),
            .reset    (reset),
            .port0    (p0),
            .port1    (p1),
            .alu_a    (o_alu_a[k]),
            .alu_b    (o_alu_b[k]),
            .alu_fun  (o_alu_fun[k]),
            .alu_sign (o_alu_sign[k]),
            .alu_s    (o_alu_s[k]),
            .busy     (o_busy[k])
        );

        assign o_alu_s[k] = alu_f(o_alu_a[k], o_alu_b[k], o_alu_fun[k], o_alu_sign[k]);

        assign p0.req_valid = r_valid[k][0];
        assign p0.req_a     = r_a[k][0];
        assign p0.req_b     = r_b[k][0];
        assign p0.req_fun   = r_fun[k][0];
        assign p0.req_sign  = r_sign[k][0];
        assign p0.req_tag   = r_tag[k][0];
        assign p0.rsp_ready = r_ready[k][0];
        assign p1.req_valid = r_valid[k][1];
        assign p1.req_a     = r_a[k][1];
        assign p1.req_b     = r_b[k][1];
        assign p1.req_fun   = r_fun[k][1];
        assign p1.req_sign  = r_sign[k][1];
        assign p1.req_tag   = r_tag[k][1];
        assign p1.rsp_ready = r_ready[k][1];

        assign o_req_ready[k][0] = p0.req_ready;
        assign o_req_ready[k][1] = p1.req_ready;
        assign o_rsp_valid[k][0] = p0.rsp_valid;
        assign o_rsp_valid[k][1] = p1.rsp_valid;
        assign o_rsp_s[k][0]     = p0.rsp_s;
        assign o_rsp_s[k][1]     = p1.rsp_s;
        assign o_rsp_tag[k][0]   = p0.rsp_tag;
        assign o_rsp_tag[k][1]   = p1.rsp_tag;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compares one instance against the model, then advances the model across the coming edge.
    task automatic step(input int k);
        logic adv, v0, v1, gv;
        int   gp;
        op_t  nop;
        check($sformatf("alu_a[%0d]", k), o_alu_a[k], m_iss_v[k] ? m_iss[k].a : 32'd0);
        check($sformatf("alu_b[%0d]", k), o_alu_b[k], m_iss_v[k] ? m_iss[k].b : 32'd0);
        check($sformatf("alu_fun[%0d]", k), 32'(o_alu_fun[k]), m_iss_v[k] ? 32'(m_iss[k].fun) : 32'd0);
        check($sformatf("alu_sign[%0d]", k), 32'(o_alu_sign[k]), m_iss_v[k] ? 32'(m_iss[k].sign) : 32'd0);
        check($sformatf("busy[%0d]", k), 32'(o_busy[k]),
              32'(m_iss_v[k] || m_slot_v[k][0] || m_slot_v[k][1]));
        for (int p = 0; p < 2; p++) begin
            check($sformatf("rsp_valid[%0d][%0d]", k, p), 32'(o_rsp_valid[k][p]), 32'(m_slot_v[k][p]));
            if (m_slot_v[k][p]) begin
                check($sformatf("rsp_s[%0d][%0d]", k, p), o_rsp_s[k][p], m_slot[k][p].s);
                check($sformatf("rsp_tag[%0d][%0d]", k, p), 32'(o_rsp_tag[k][p]), 32'(m_slot[k][p].tag));
            end
        end

        adv = !m_iss_v[k] || !m_slot_v[k][m_owner[k]] || r_ready[k][m_owner[k]];
        v0  = r_valid[k][0];
        v1  = r_valid[k][1];
        gv  = adv && (v0 || v1);
        if (v0 && v1) gp = (k == 0) ? 1 - m_last[k] : ((m_starve[k] == LIMIT) ? 1 : 0);
        else          gp = v1 ? 1 : 0;

        check($sformatf("ready_onehot[%0d]", k), 32'(o_req_ready[k][0] && o_req_ready[k][1]), 32'd0);
        for (int p = 0; p < 2; p++) begin
            if (r_valid[k][p]) begin
                check($sformatf("req_ready[%0d][%0d]", k, p), 32'(o_req_ready[k][p]), 32'(gv && gp == p));
                if (o_req_ready[k][p] && grant_n[k] < 32) begin
                    grant_log[k][grant_n[k]] = p;
                    grant_n[k]++;
                end
            end
            if (o_rsp_valid[k][p] && r_ready[k][p] && rsp_n[k][p] < 16) begin
                rsp_log[k][p][rsp_n[k][p]] = '{s: o_rsp_s[k][p], tag: o_rsp_tag[k][p], cyc: cyc};
                rsp_n[k][p]++;
            end
            if (m_slot_v[k][p] && r_ready[k][p]) m_slot_v[k][p] = 1'b0;
        end

        if (adv && m_iss_v[k]) begin
            m_slot[k][m_owner[k]]   = m_iss[k];
            m_slot_v[k][m_owner[k]] = 1'b1;
        end
        if (adv) begin
            m_iss_v[k] = gv;
            if (gv) begin
                nop.a    = r_a[k][gp];
                nop.b    = r_b[k][gp];
                nop.fun  = r_fun[k][gp];
                nop.sign = r_sign[k][gp];
                nop.tag  = r_tag[k][gp];
                nop.s    = alu_f(nop.a, nop.b, nop.fun, nop.sign);
                m_iss[k]   = nop;
                m_owner[k] = gp;
            end
        end
        if (gv) m_last[k] = gp;
        if (k == 1 && v1 && !(gv && gp == 1)) m_starve[k] = (m_starve[k] < 15) ? m_starve[k] + 1 : 15;
        else m_starve[k] = 0;
    endtask

    always @(negedge clk) begin : compare
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                check($sformatf("ready0_in_reset[%0d]", k), 32'(o_req_ready[k][0]), 32'd0);
                check($sformatf("ready1_in_reset[%0d]", k), 32'(o_req_ready[k][1]), 32'd0);
                m_iss_v[k]     = 1'b0;
                m_owner[k]     = 0;
                m_slot_v[k][0] = 1'b0;
                m_slot_v[k][1] = 1'b0;
                m_last[k]      = 1;
                m_starve[k]    = 0;
            end else begin
                step(k);
            end
        end
    end

    task automatic issue_op(input int k, input int p, input logic [31:0] a, input logic [31:0] b,
                            input logic [5:0] fun, input logic sign, input logic [TW-1:0] tag);
        logic done;
        done = 1'b0;
        r_a[k][p]     = a;
        r_b[k][p]     = b;
        r_fun[k][p]   = fun;
        r_sign[k][p]  = sign;
        r_tag[k][p]   = tag;
        r_valid[k][p] = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (o_req_ready[k][p]) done = 1'b1;
        end
        check($sformatf("accept_timeout[%0d][%0d]", k, p), 32'(done), 32'd1);
        @(posedge clk);
        #1;
        r_valid[k][p] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 2; k++) begin
            grant_n[k]  = 0;
            rsp_n[k][0] = 0;
            rsp_n[k][1] = 0;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                r_valid[k][p] = 1'b0;
                r_a[k][p]     = '0;
                r_b[k][p]     = '0;
                r_fun[k][p]   = '0;
                r_sign[k][p]  = 1'b0;
                r_tag[k][p]   = '0;
                r_ready[k][p] = 1'b1;
            end
        end
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Single ADD on port 0
        issue_op(0, 0, 32'd5, 32'd7, ALU_ADD, 1'b0, 4'd3);
        idle(3);
        check("add_count", 32'(rsp_n[0][0]), 32'd1);
        check("add_s", rsp_log[0][0][0].s, 32'd12);
        check("add_tag", 32'(rsp_log[0][0][0].tag), 32'd3);
        @(negedge clk);
        check("add_alu_a_idle", o_alu_a[0], 32'd0);
        check("add_busy_idle", 32'(o_busy[0]), 32'd0);
        @(posedge clk);
        #1;

        // Round-robin alternation
        pulse_reset();
        clear_logs();
        fork
            begin
                issue_op(0, 0, 32'd10, 32'd3, ALU_SUB, 1'b0, 4'd1);
                issue_op(0, 0, 32'd10, 32'd3, ALU_SUB, 1'b0, 4'd2);
            end
            begin
                issue_op(0, 1, 32'd4, 32'd1, ALU_SLL, 1'b0, 4'd5);
                issue_op(0, 1, 32'd4, 32'd1, ALU_SLL, 1'b0, 4'd6);
            end
        join
        idle(3);
        check("rr_grant_count", 32'(grant_n[0]), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), 32'(grant_log[0][i]), 32'(exp_rr[i]));
        check("rr_sub_s", rsp_log[0][0][1].s, 32'd7);
        check("rr_sll_s", rsp_log[0][1][0].s, 32'd16);
        check("rr_sll_tag", 32'(rsp_log[0][1][1].tag), 32'd6);

        // Fixed priority with starvation guard
        clear_logs();
        fork
            for (int i = 0; i < 10; i++) issue_op(1, 0, 32'(i), 32'd1, ALU_ADD, 1'b0, 4'(i));
            for (int i = 0; i < 2; i++) issue_op(1, 1, 32'(100 + i), 32'd0, ALU_PASSA, 1'b0, 4'(i));
        join
        idle(3);
        check("fx_grant_count", 32'(grant_n[1]), 32'd12);
        for (int i = 0; i < 12; i++) check($sformatf("fx_grant%0d", i), 32'(grant_log[1][i]), 32'(exp_fx[i]));
        check("fx_p1_s", rsp_log[1][1][1].s, 32'd101);

        // Stall with port-0 response held
        clear_logs();
        r_ready[0][0] = 1'b0;
        fork
            begin
                issue_op(0, 0, 32'h0000F0F0, 32'h00000FF0, ALU_AND, 1'b0, 4'd1);
                issue_op(0, 0, 32'h0000F0F0, 32'h00000FF0, ALU_OR,  1'b0, 4'd2);
                issue_op(0, 0, 32'h0000F0F0, 32'h00000FF0, ALU_XOR, 1'b0, 4'd3);
            end
            begin
                repeat (4) @(negedge clk);
                check("stall_rsp_s", o_rsp_s[0][0], 32'h000000F0);
                check("stall_alu_a", o_alu_a[0], 32'h0000F0F0);
                check("stall_alu_fun", 32'(o_alu_fun[0]), 32'(ALU_OR));
                check("stall_ready0", 32'(o_req_ready[0][0]), 32'd0);
                check("stall_ready1", 32'(o_req_ready[0][1]), 32'd0);
                @(negedge clk);
                check("stall_alu_b_hold", o_alu_b[0], 32'h00000FF0);
                check("stall_alu_fun_hold", 32'(o_alu_fun[0]), 32'(ALU_OR));
                @(posedge clk);
                #1;
                r_ready[0][0] = 1'b1;
            end
        join
        idle(3);
        check("stall_count", 32'(rsp_n[0][0]), 32'd3);
        check("stall_r0", rsp_log[0][0][0].s, 32'h000000F0);
        check("stall_r1", rsp_log[0][0][1].s, 32'h0000FFF0);
        check("stall_r2", rsp_log[0][0][2].s, 32'h0000FF00);
        check("stall_gap01", 32'(rsp_log[0][0][1].cyc - rsp_log[0][0][0].cyc), 32'd1);
        check("stall_gap12", 32'(rsp_log[0][0][2].cyc - rsp_log[0][0][1].cyc), 32'd1);

        // Compares, sign select and an illegal function code
        clear_logs();
        fork
            issue_op(0, 1, 32'hFFFFFFFF, 32'd1, ALU_LT, 1'b1, 4'hA);
            issue_op(0, 0, 32'h00001234, 32'h00001234, ALU_EQ, 1'b0, 4'hB);
        join
        issue_op(0, 0, 32'd5, 32'd6, 6'b001111, 1'b0, 4'hC);
        issue_op(0, 1, 32'hFFFFFFFF, 32'd1, ALU_LT, 1'b0, 4'hD);
        idle(3);
        check("slt_s", rsp_log[0][1][0].s, 32'd1);
        check("eq_s", rsp_log[0][0][0].s, 32'd1);
        check("illegal_s", rsp_log[0][0][1].s, 32'd0);
        check("illegal_tag", 32'(rsp_log[0][0][1].tag), 32'hC);
        check("ult_s", rsp_log[0][1][1].s, 32'd0);

        // Reset with issue valid and port-1 slot full
        clear_logs();
        r_ready[0][1] = 1'b0;
        issue_op(0, 1, 32'd1, 32'd2, ALU_ADD, 1'b0, 4'd9);
        issue_op(0, 0, 32'd3, 32'd4, ALU_ADD, 1'b0, 4'd8);
        check("pre_rst_rsp1_valid", 32'(o_rsp_valid[0][1]), 32'd1);
        check("pre_rst_alu_a", o_alu_a[0], 32'd3);
        pulse_reset();
        @(negedge clk);
        check("post_rst_rsp0_valid", 32'(o_rsp_valid[0][0]), 32'd0);
        check("post_rst_rsp1_valid", 32'(o_rsp_valid[0][1]), 32'd0);
        check("post_rst_busy", 32'(o_busy[0]), 32'd0);
        @(posedge clk);
        #1;
        r_ready[0][1] = 1'b1;
        issue_op(0, 0, 32'd9, 32'd4, ALU_SUB, 1'b0, 4'd7);
        idle(4);
        check("post_rst_count0", 32'(rsp_n[0][0]), 32'd1);
        check("post_rst_s", rsp_log[0][0][0].s, 32'd5);
        check("post_rst_tag", 32'(rsp_log[0][0][0].tag), 32'd7);
        check("post_rst_count1", 32'(rsp_n[0][1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
